// File: rtl/des_pkg.sv
// Purpose: shared DES key-schedule constants, permutation tables and rotate helpers.
// Latency: n/a (package; functions are purely combinational).
// Backpressure: n/a.
package des_pkg;

    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int CD_W     = 56;
    localparam int KEY_W    = 64;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } des_mode_e;

    // Left-rotation amount per round (rounds numbered 1..16).
    localparam int unsigned SHIFT_TABLE [1:16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // PC-1: source key bit (1 = MSB) for each of the 56 CD bits.
    localparam int unsigned PC1_TBL [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: source CD bit for each of the 48 subkey bits.
    localparam int unsigned PC2_TBL [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // PC-1 load-path permutation; parity bits 8,16,..,64 are never selected.
    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        for (int i = 1; i <= 56; i++) begin
            r[i] = k[PC1_TBL[i]];
        end
        return r;
    endfunction

    // Shift amount of a round; rounds outside 1..16 never reach a rotate.
    function automatic logic [1:0] shift_of(input logic [4:0] round);
        int unsigned r;
        r = 32'(round);
        if (r >= 1 && r <= 16) begin
            return 2'(SHIFT_TABLE[r]);
        end
        return 2'd1;
    endfunction

    // 28-bit circular left rotate by 1 or 2 (bit 1 is the MSB).
    function automatic logic [1:28] rotl28(input logic [1:28] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[3:28], v[1:2]} : {v[2:28], v[1]};
    endfunction

    // 28-bit circular right rotate by 1 or 2.
    function automatic logic [1:28] rotr28(input logic [1:28] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[27:28], v[1:26]} : {v[28], v[1:27]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Purpose: PC-2 compression permutation, 56-bit CD -> 48-bit round subkey.
// Latency: combinational.
// Backpressure: n/a.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:56] i_cd,
    output logic [1:48] o_subkey
);

    // CD bits 9,18,22,25,35,38,43,54 are dropped by PC-2.
    logic w_dropped_unused;
    assign w_dropped_unused = ^{i_cd[9], i_cd[18], i_cd[22], i_cd[25],
                                i_cd[35], i_cd[38], i_cd[43], i_cd[54]};

    // Pure bit selection through the PC-2 table.
    always_comb begin
        o_subkey = '0;
        for (int i = 1; i <= 48; i++) begin
            o_subkey[i] = i_cd[PC2_TBL[i]];
        end
    end

endmodule

// File: rtl/des_subkey_gen.sv
// Purpose: sequential DES round-key generator streaming K1..K16 (enc) or K16..K1 (dec).
// Latency: first subkey valid the cycle after start; one subkey per cycle when ready stays high.
// Backpressure: subkey/subkey_idx held stable while subkey_valid=1 and subkey_ready=0.
module des_subkey_gen
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:64] key,
    input  logic        decrypt,
    input  logic        start,
    input  logic        abort,
    output logic [1:48] subkey,
    output logic [3:0]  subkey_idx,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        busy,
    output logic        done
);

    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_RUN   = 1'b1;
    localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

    logic        r_state;
    des_mode_e   r_mode;
    logic [1:28] r_c;
    logic [1:28] r_d;
    logic [3:0]  r_cnt;
    logic [1:48] r_subkey;
    logic [3:0]  r_subkey_idx;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;

    logic        w_load;
    logic        w_xfer;
    logic        w_last;
    logic        w_step;
    logic [1:56] w_pc1;
    logic [4:0]  w_round;
    logic [1:0]  w_shift;
    logic [1:28] w_c_next;
    logic [1:28] w_d_next;
    logic [1:48] w_pc2;
    logic        w_parity_unused;

    // Parity bits of the key carry no key material.
    assign w_parity_unused = ^{key[8], key[16], key[24], key[32],
                               key[40], key[48], key[56], key[64]};

    assign w_load = (r_state == ST_IDLE) && start && !abort;
    assign w_xfer = (r_state == ST_RUN) && r_valid && subkey_ready;
    assign w_last = w_xfer && (r_cnt == LAST_CNT);
    assign w_step = w_xfer && !w_last && !abort;
    assign w_pc1  = pc1(key);

    // Encrypt advances to round idx+2 (next subkey); decrypt undoes round idx+1 (subkey just sent).
    assign w_round = (r_mode == MODE_DEC) ? ({1'b0, r_subkey_idx} + 5'd1)
                                          : ({1'b0, r_subkey_idx} + 5'd2);
    assign w_shift = shift_of(w_round);

    // Next C/D: PC-1 load (pre-rotated for encrypt, since C16/D16 = C0/D0 for decrypt) or a round step.
    always_comb begin
        w_c_next = r_c;
        w_d_next = r_d;
        if (w_load) begin
            if (decrypt) begin
                w_c_next = w_pc1[1:28];
                w_d_next = w_pc1[29:56];
            end else begin
                w_c_next = rotl28(w_pc1[1:28],  2'(SHIFT_TABLE[1]));
                w_d_next = rotl28(w_pc1[29:56], 2'(SHIFT_TABLE[1]));
            end
        end else if (w_step) begin
            if (r_mode == MODE_DEC) begin
                w_c_next = rotr28(r_c, w_shift);
                w_d_next = rotr28(r_d, w_shift);
            end else begin
                w_c_next = rotl28(r_c, w_shift);
                w_d_next = rotl28(r_d, w_shift);
            end
        end
    end

    // Subkey is computed from the next C/D so it is registered alongside it.
    des_pc2 u_pc2 (
        .i_cd     ({w_c_next, w_d_next}),
        .o_subkey (w_pc2)
    );

    // Key-state datapath: C/D and the registered subkey update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c      <= '0;
            r_d      <= '0;
            r_subkey <= '0;
        end else if (w_load || w_step) begin
            r_c      <= w_c_next;
            r_d      <= w_d_next;
            r_subkey <= w_pc2;
        end
    end

    // Control FSM: abort wins over start and transfer; done pulses after the final transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_ENC;
            r_cnt        <= '0;
            r_subkey_idx <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode       <= des_mode_e'(decrypt);
                        r_cnt        <= '0;
                        r_subkey_idx <= decrypt ? LAST_CNT : 4'd0;
                        r_valid      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_xfer) begin
                        r_cnt        <= r_cnt + 4'd1;
                        r_subkey_idx <= (r_mode == MODE_DEC) ? (r_subkey_idx - 4'd1)
                                                             : (r_subkey_idx + 4'd1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign subkey       = r_subkey;
    assign subkey_idx   = r_subkey_idx;
    assign subkey_valid = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_des_subkey_gen.sv
module tb_des_subkey_gen;

    typedef struct packed {
        logic [3:0]  idx;
        logic [47:0] k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:64] key;
    logic        decrypt;
    logic        start;
    logic        abort;
    logic [1:48] subkey;
    logic [3:0]  subkey_idx;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb[$];

    // Hand-derived schedule for key 0x133457799BBCDFF1, K1..K16.
    logic [47:0] KTAB [0:15] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    localparam logic [1:64] K_MAIN   = 64'h133457799BBCDFF1;
    localparam logic [1:64] K_PARITY = 64'h133457799BBCDFF1 ^ 64'h0101010101010101;

    des_subkey_gen #(.NUM_ROUNDS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key          (key),
        .decrypt      (decrypt),
        .start        (start),
        .abort        (abort),
        .subkey       (subkey),
        .subkey_idx   (subkey_idx),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    logic        stall_prev = 1'b0;
    logic [47:0] prev_k;
    logic [3:0]  prev_idx;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(subkey_valid), 64'd1);
                check("stall_subkey", 64'(subkey), 64'(prev_k));
                check("stall_idx", 64'(subkey_idx), 64'(prev_idx));
            end
            if (subkey_valid && subkey_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got idx %0d subkey %h, expected none", subkey_idx, subkey);
                end else begin
                    e = sb.pop_front();
                    check("xfer_idx", 64'(subkey_idx), 64'(e.idx));
                    check("xfer_subkey", 64'(subkey), 64'(e.k));
                end
            end
            stall_prev = subkey_valid && !subkey_ready && !abort;
            prev_k     = subkey;
            prev_idx   = subkey_idx;
        end
    end

    // Issue start and queue the expected 16 subkeys in emission order.
    task automatic start_sched(input logic [1:64] k, input logic dec);
        for (int i = 0; i < 16; i++) begin
            int n;
            n = dec ? (15 - i) : i;
            sb.push_back({4'(n), KTAB[n]});
        end
        key     = k;
        decrypt = dec;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("valid_after_start", 64'(subkey_valid), 64'd1);
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    // Drive ready until done; optionally random ready and a mid-run start/key disturbance.
    task automatic wait_done(input bit rnd, input bit disturb, input int exp_cycles);
        int cyc;
        cyc = 0;
        for (int c = 1; c <= 400; c++) begin
            cyc = c;
            subkey_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (disturb && c == 4) begin
                start   = 1'b1;
                decrypt = ~decrypt;
                key     = ~key;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) break;
        end
        start = 1'b0;
        check("done_seen", 64'(done), 64'd1);
        if (exp_cycles >= 0) check("done_latency", 64'(cyc), 64'(exp_cycles));
        check("busy_at_done", 64'(busy), 64'd0);
        check("valid_at_done", 64'(subkey_valid), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        key          = '0;
        decrypt      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        subkey_ready = 1'b0;
        #12;
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_idx", 64'(subkey_idx), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back encrypt and decrypt, one subkey per cycle.
        start_sched(K_MAIN, 1'b0);
        wait_done(1'b0, 1'b0, 16);
        @(posedge clk); #1;
        start_sched(K_MAIN, 1'b1);
        wait_done(1'b0, 1'b0, 16);
        @(posedge clk); #1;

        // Random backpressure in both modes.
        start_sched(K_MAIN, 1'b0);
        wait_done(1'b1, 1'b0, -1);
        @(posedge clk); #1;
        start_sched(K_MAIN, 1'b1);
        wait_done(1'b1, 1'b0, -1);
        @(posedge clk); #1;

        // Parity-only key change, then a start issued in the done cycle.
        start_sched(K_PARITY, 1'b0);
        wait_done(1'b0, 1'b0, 16);
        start_sched(K_MAIN, 1'b1);
        wait_done(1'b0, 1'b0, 16);
        @(posedge clk); #1;

        // start/key/decrypt wiggled mid-run must not disturb the schedule.
        start_sched(K_MAIN, 1'b0);
        wait_done(1'b0, 1'b1, 16);
        @(posedge clk); #1;

        // Abort while idx 5 is presented, then a clean schedule.
        start_sched(K_MAIN, 1'b0);
        subkey_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("abort_at_idx", 64'(subkey_idx), 64'd5);
        check("abort_sb_left", 64'(sb.size()), 64'd11);
        sb.delete();
        subkey_ready = 1'b0;
        abort        = 1'b1;
        start        = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_valid", 64'(subkey_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        start_sched(K_MAIN, 1'b0);
        wait_done(1'b0, 1'b0, 16);
        @(posedge clk); #1;

        // Reset mid-run while idx 9 (decrypt order) is presented, then a clean schedule.
        start_sched(K_MAIN, 1'b1);
        subkey_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("rstrun_at_idx", 64'(subkey_idx), 64'd9);
        check("rstrun_sb_left", 64'(sb.size()), 64'd10);
        sb.delete();
        subkey_ready = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("rstrun_valid", 64'(subkey_valid), 64'd0);
        check("rstrun_busy", 64'(busy), 64'd0);
        check("rstrun_idx", 64'(subkey_idx), 64'd0);
        check("rstrun_subkey", 64'(subkey), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_sched(K_MAIN, 1'b0);
        wait_done(1'b0, 1'b0, 16);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/des_subkey_gen.md
Name: des_subkey_gen

Overview:
- Sequential DES/3DES round-key generator; counterpart of the PC-1 front end.
- Takes a 64-bit key, applies PC-1 and the per-round rotations, and streams the 16 PC-2 subkeys to the round datapath over a valid/ready handshake.
- Encrypt mode emits K1..K16 using left rotations. Decrypt mode emits K16..K1 using right rotations, so the key is never pre-expanded.
- One instance per DES stage of the 3DES core.

Parameters:
- NUM_ROUNDS, 16, number of subkeys per key; fixed by DES, exposed for the bench only.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,…,64 ignored
- decrypt  in  1  0 = emit K1..K16, 1 = emit K16..K1; sampled with start
- start  in  1  request a new schedule; accepted only when busy=0
- abort  in  1  synchronous cancel; returns to IDLE next cycle
- subkey  out  [1:48]  current round subkey Kn
- subkey_idx  out  4  n-1 of the subkey presented (0..15)
- subkey_valid  out  1  subkey/subkey_idx are valid
- subkey_ready  in  1  consumer accepts subkey this cycle
- busy  out  1  schedule in progress
- done  out  1  one-cycle pulse after the 16th transfer

Behaviour:
- Reset (rst_n=0, async): state IDLE; C/D register, counter, subkey, subkey_idx, subkey_valid, busy, done all 0.
- Shift table (FIPS 46-3, round 1..16): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- States: IDLE, RUN.
- IDLE + start:
  - Latch decrypt into mode_r.
  - Load CD = PC1(key), with C = bits 1..28 and D = bits 29..56.
  - Encrypt: load CD already rotated left by shift[1].
  - Decrypt: load unrotated CD, because C16/D16 = C0/D0.
  - Set busy=1 and go to RUN. subkey_valid=1 in the cycle after start.
- start while busy=1 is ignored. key/decrypt changes during RUN have no effect.
- RUN output: subkey = PC2(C,D), registered, and held stable while subkey_valid=1 and subkey_ready=0.
  - subkey_idx counts 0→15 in encrypt and 15→0 in decrypt.
- Transfer occurs on subkey_valid & subkey_ready. On a transfer (not the last):
  - Encrypt: rotate C and D left by shift[n+1].
  - Decrypt: rotate C and D right by shift[n], where n is the index of the subkey just transferred.
  - The next subkey is valid in the following cycle. No bubble is allowed: back-to-back ready yields one subkey per cycle.
- Last transfer (16th): next cycle subkey_valid=0, busy=0, done=1 for exactly one cycle, state IDLE. After the last rotation, CD equals the original PC1 value.
- start may be asserted in the same cycle done=1; it is accepted (state is IDLE).
- abort (any state): next cycle IDLE, subkey_valid=0, busy=0, done=0. abort outranks start and transfer in the same cycle.
- Reset mid-RUN: immediate return to reset values. No partial schedule resumes.
- Rotations are 28-bit circular on C and D independently; no arithmetic widths beyond the 4-bit counter, which never wraps within a schedule.

Decomposition:
- Shared package des_pkg:
  - SHIFT_TABLE[1:16]
  - PC1 and PC2 index tables
  - 28/48/56/64 width constants
  - mode encoding ENC=0/DEC=1
- Reuse the existing PC-1 permutation block for the load path.
- One natural combinational sub-module: des_pc2 (56→48 permutation).
- Rotation logic is inline in des_subkey_gen.

Test Plan:
- Encrypt, key=0x133457799BBCDFF1, ready held 1 → 16 consecutive valid cycles; idx 0 subkey=0x1B02EFFC7072, idx 1 = 0x79AED9DBC9E5, idx 15 = 0xCB3D8B0E17F5; done pulses one cycle after the last.
- Decrypt, same key → first subkey=0xCB3D8B0E17F5 (idx 15), last =0x1B02EFFC7072 (idx 0); the full sequence is the exact reverse of the encrypt run.
- Backpressure: ready random 30% duty → subkey/idx stable while stalled; exactly 16 transfers; values identical to the unstalled run.
- Parity independence: key=0x133457799BBCDFF1 vs 0x123456789ABCDEF0-style parity-bit flips only (e.g. XOR 0x0101010101010101) → identical subkeys.
- start during RUN and key change mid-run → ignored; sequence unchanged. start in the done cycle → new schedule begins, valid next cycle.
- abort at idx 5, and rst_n low at idx 9 → valid=0/busy=0 next cycle (reset immediately); following start produces a correct full schedule from idx 0.
